// File: rtl/aes_inv_round.sv
// One pipelined AES inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Builds its inverse S-box table after reset, then accepts one block per clock with fixed 4-cycle latency.

module aes_inv_round #(
  parameter int unsigned FINAL_ROUND = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] in_data,
  input  logic         in_ready,
  input  logic [0:127] round_key,
  output logic [0:127] out_data,
  output logic         out_ready,
  output logic         s_box_ready
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned BLK_W  = BYTE_W * NBYTES;
  localparam int unsigned COL_W  = 4 * BYTE_W;
  localparam int unsigned TAB_N  = 256;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // GF(2^8) arithmetic, polynomial 0x11B
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0)
  function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Row r rotated right by r byte positions
  function automatic logic [0:BLK_W-1] inv_shift_rows(input logic [0:BLK_W-1] s);
    logic [0:BLK_W-1] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[BYTE_W*(r+4*c) +: BYTE_W] = s[BYTE_W*(r+4*((c-r+4)%4)) +: BYTE_W];
      end
    end
    return o;
  endfunction

  function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] col);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [0:BLK_W-1] inv_mix(input logic [0:BLK_W-1] s);
    logic [0:BLK_W-1] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[COL_W*c +: COL_W] = inv_mix_col(s[COL_W*c +: COL_W]);
    end
    return o;
  endfunction

  state_t              state;
  logic [BYTE_W-1:0]   cnt;
  logic [BYTE_W-1:0]   inv_tab [TAB_N];

  logic                accept;
  logic                s0_valid, s1_valid, s2_valid, s3_valid;
  logic [0:BLK_W-1]    s0_data, s0_key;
  logic [0:BLK_W-1]    s1_data, s1_key;
  logic [0:BLK_W-1]    s2_data, s2_key;
  logic [0:BLK_W-1]    s3_data;
  logic [0:BLK_W-1]    sub_c;
  logic [0:BLK_W-1]    mix_c;

  assign accept = in_ready && s_box_ready;

  // Init sequencer: walks cnt 0..255 filling the inverse table, then parks in RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      cnt         <= '0;
      s_box_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hff) begin
            state       <= ST_RUN;
            s_box_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          s_box_ready <= 1'b1;
        end
      endcase
    end
  end

  // Inverse table: forward S-box output indexes the location holding its preimage
  always_ff @(posedge clk) begin
    if (!reset && state == ST_INIT) begin
      inv_tab[sbox_fwd(cnt)] <= cnt;
    end
  end

  always_comb begin
    sub_c = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      sub_c[BYTE_W*i +: BYTE_W] = inv_tab[s1_data[BYTE_W*i +: BYTE_W]];
    end
  end

  if (FINAL_ROUND != 0) begin : g_final
    assign mix_c = s3_data;
  end else begin : g_mid
    assign mix_c = inv_mix(s3_data);
  end

  // Valid chain and output register; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_ready <= 1'b0;
      out_data  <= '0;
    end else begin
      s0_valid  <= accept;
      s1_valid  <= s0_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_ready <= s3_valid;
      if (s3_valid) out_data <= mix_c;
    end
  end

  // Datapath registers; only loaded when their stage carries a block
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_data <= in_data;
      s0_key  <= round_key;
    end
    if (s0_valid) begin
      s1_data <= inv_shift_rows(s0_data);
      s1_key  <= s0_key;
    end
    if (s1_valid) begin
      s2_data <= sub_c;
      s2_key  <= s1_key;
    end
    if (s2_valid) begin
      s3_data <= s2_data ^ s2_key;
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard bench for aes_inv_round: a mid-round and a final-round instance share stimulus,
// and a 14-instance chain decrypts the FIPS-197 AES-256 example.

module tb_aes_inv_round;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:127] in_data;
  logic         in_ready;
  logic [0:127] round_key;

  logic [0:127] mid_out, fin_out;
  logic         mid_ordy, fin_ordy, mid_sbr, fin_sbr;

  logic [0:127] chain_in;
  logic         chain_go;
  logic [0:127] ch_data [15];
  logic         ch_rdy  [15];
  logic         ch_sbr  [14];
  logic [0:127] rk      [15];

  logic [0:127] q_mid   [$];
  logic [0:127] q_fin   [$];
  logic [0:127] q_chain [$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_inv_round #(.FINAL_ROUND(0)) u_mid (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready), .round_key(round_key),
    .out_data(mid_out), .out_ready(mid_ordy), .s_box_ready(mid_sbr));

  aes_inv_round #(.FINAL_ROUND(1)) u_fin (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready), .round_key(round_key),
    .out_data(fin_out), .out_ready(fin_ordy), .s_box_ready(fin_sbr));

  assign ch_data[0] = chain_in;
  assign ch_rdy[0]  = chain_go;

  for (genvar k = 0; k < 14; k++) begin : g_chain
    aes_inv_round #(.FINAL_ROUND((k == 13) ? 1 : 0)) u_rnd (
      .clk(clk), .reset(reset), .in_data(ch_data[k]), .in_ready(ch_rdy[k]),
      .round_key(rk[13-k]), .out_data(ch_data[k+1]), .out_ready(ch_rdy[k+1]),
      .s_box_ready(ch_sbr[k]));
  end

  // Key-schedule helpers (forward S-box only)
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = m_mul(r, a);
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_subword(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  task automatic build_keys();
    logic [0:255] key;
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    rc  = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = m_xt(rc);
      end else if (i % 8 == 4) begin
        t = m_subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check128(input string name, input logic [0:127] act, input logic [0:127] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (mid_ordy === 1'b1) begin
      if (q_mid.size() == 0) check_int("mid_unexpected_out_ready", 1, 0);
      else check128("mid_out", mid_out, q_mid.pop_front());
    end
    if (fin_ordy === 1'b1) begin
      if (q_fin.size() == 0) check_int("fin_unexpected_out_ready", 1, 0);
      else check128("fin_out", fin_out, q_fin.pop_front());
    end
    if (ch_rdy[14] === 1'b1) begin
      if (q_chain.size() == 0) check_int("chain_unexpected_out_ready", 1, 0);
      else check128("chain_plaintext", ch_data[14], q_chain.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until ready; optionally pulse in_ready while waiting (those must be dropped)
  task automatic wait_ready(input bit poke, output int n);
    n = 0;
    while (mid_sbr !== 1'b1 && n < 400) begin
      if (poke) begin
        in_ready  = n[0];
        in_data   = {16{8'h00}};
        round_key = {16{8'h3c}};
      end
      tick();
      n++;
    end
    in_ready = 1'b0;
  endtask

  task automatic send(input logic [0:127] d, input logic [0:127] k,
                      input logic [0:127] em, input logic [0:127] ef);
    in_data   = d;
    round_key = k;
    in_ready  = 1'b1;
    q_mid.push_back(em);
    q_fin.push_back(ef);
    tick();
    in_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_mid.size() + q_fin.size() + q_chain.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    check_int("drain_pending", q_mid.size() + q_fin.size() + q_chain.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] k;
    reset     = 1'b1;
    in_ready  = 1'b0;
    in_data   = '0;
    round_key = '0;
    chain_go  = 1'b0;
    chain_in  = '0;
    build_keys();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_int("rst_mid_out_ready", int'(mid_ordy), 0);
    check128 ("rst_mid_out_data", mid_out, '0);
    check_int("rst_mid_s_box_ready", int'(mid_sbr), 0);
    check_int("rst_fin_out_ready", int'(fin_ordy), 0);

    // Init window length
    wait_ready(1'b0, n);
    check_int("init_cycles", n, 256);
    check_int("fin_s_box_ready", int'(fin_sbr), 1);
    check_int("chain_s_box_ready", int'(ch_sbr[13]), 1);

    // Uniform-byte states: both instances give the same answer (coefficient sum 01)
    send({16{8'h00}}, {16{8'h00}}, {16{8'h52}}, {16{8'h52}});
    idle_gap();
    send({16{8'h00}}, {16{8'hff}}, {16{8'had}}, {16{8'had}});
    send({16{8'h63}}, {16{8'h00}}, {16{8'h00}}, {16{8'h00}});
    drain();
    tick();
    check128 ("mid_hold_out_data", mid_out, {16{8'h00}});
    check_int("mid_out_ready_idle", int'(mid_ordy), 0);

    // Row rotation direction: one distinct byte per row in column 0
    send(128'hf27c777b636363636363636363636363, {16{8'h00}},
         128'h3824342c0b0e090d1a161c121b171d12,
         128'h04000000000100000000020000000003);
    // Known InvMixColumns pairs; key chosen so the post-AddRoundKey state is the target
    send({16{8'h00}},
         {32'h8e4da1bc, 32'h9fdc589d, 32'h8e4da1bc, 32'h9fdc589d} ^ {16{8'h52}},
         {32'hdb135345, 32'hf20a225c, 32'hdb135345, 32'hf20a225c},
         {32'h8e4da1bc, 32'h9fdc589d, 32'h8e4da1bc, 32'h9fdc589d});
    drain();

    // Eight back-to-back blocks, each with its own key
    for (int i = 0; i < 8; i++) begin
      k = 8'(i * 29 + 7);
      send({16{8'h00}}, {16{k}}, {16{8'h52 ^ k}}, {16{8'h52 ^ k}});
    end
    drain();

    // AES-256 decryption through the 14-round chain
    chain_in = 128'h8ea2b7ca516745bfeafc49904b496089 ^ rk[14];
    chain_go = 1'b1;
    q_chain.push_back(128'h00112233445566778899aabbccddeeff);
    tick();
    chain_go = 1'b0;
    drain();
    check_int("s_box_ready_held", int'(mid_sbr), 1);

    // Reset with three blocks in flight
    in_data   = {16{8'h00}};
    round_key = {16{8'h00}};
    in_ready  = 1'b1;
    repeat (3) tick();
    in_ready = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check_int("rst2_out_ready", int'(mid_ordy), 0);
    check128 ("rst2_out_data", mid_out, '0);
    check_int("rst2_s_box_ready", int'(mid_sbr), 0);
    wait_ready(1'b1, n);
    check_int("reinit_cycles", n, 256);
    send({16{8'hed}}, {16{8'h00}}, {16{8'h53}}, {16{8'h53}});
    drain();
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic idle_gap();
    repeat (6) tick();
  endtask

endmodule
